// File: rtl/centrifugado_temporizador.sv
// centrifugado_temporizador: drain/spin/brake sequencer timed by a 1 Hz tick enable
module centrifugado_temporizador #(
  parameter int unsigned T_CENTRI_1 = 150,
  parameter int unsigned T_CENTRI_2 = 200,
  parameter int unsigned T_CENTRI_3 = 275,
  parameter int unsigned T_CENTRI_4 = 375,
  parameter int unsigned T_VACIAR   = 10,
  parameter int unsigned T_FRENADO  = 5
) (
  input  logic       clk_in,
  input  logic       iReset,
  input  logic       iTick_1Hz,
  input  logic       iCentrifugarL,
  input  logic       iStart,
  input  logic       iPausa,
  input  logic       iCentri_1,
  input  logic       iCentri_2,
  input  logic       iCentri_3,
  input  logic       iCentri_4,
  output logic       iLed_Motor,
  output logic       iLed_Vaceando,
  output logic [8:0] iCuenta,
  output logic [2:0] iEstado,
  output logic       iFin,
  output logic       iError
);
  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    VACIAR      = 3'd1,
    CENTRIFUGAR = 3'd2,
    FRENADO     = 3'd3,
    FIN         = 3'd4
  } estado_t;
  estado_t    estado_q;
  logic [8:0] cuenta_q, tiempo_q;
  logic       motor_q, vac_q, fin_q, error_q;
  logic       sel_ok, avanza;
  logic [8:0] sel_t;
  assign sel_ok = $onehot({iCentri_4, iCentri_3, iCentri_2, iCentri_1});
  assign sel_t  = iCentri_1 ? 9'(T_CENTRI_1) : iCentri_2 ? 9'(T_CENTRI_2) :
                  iCentri_3 ? 9'(T_CENTRI_3) : 9'(T_CENTRI_4);
  // a tick only counts while not paused; pause always wins
  assign avanza = iTick_1Hz && !iPausa;
  // phase sequencing, countdown and registered LED/done outputs
  always_ff @(posedge clk_in or posedge iReset)
    if (iReset) begin
      estado_q <= IDLE;
      cuenta_q <= 9'd0;
      tiempo_q <= 9'd0;
      motor_q  <= 1'b0;
      vac_q    <= 1'b0;
      fin_q    <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      fin_q <= 1'b0;
      case (estado_q)
        IDLE:
          if (iStart && iCentrifugarL && sel_ok) begin
            estado_q <= VACIAR;
            cuenta_q <= 9'(T_VACIAR);
            tiempo_q <= sel_t;
            vac_q    <= 1'b1;
            error_q  <= 1'b0;
          end else if (iStart && !sel_ok)
            error_q <= 1'b1;
        FIN:
          estado_q <= IDLE;
        VACIAR, CENTRIFUGAR, FRENADO:
          if (!iCentrifugarL) begin
            estado_q <= IDLE;
            cuenta_q <= 9'd0;
            motor_q  <= 1'b0;
            vac_q    <= 1'b0;
          end else if (avanza && cuenta_q == 9'd1)
            case (estado_q)
              VACIAR: begin
                estado_q <= CENTRIFUGAR;
                cuenta_q <= tiempo_q;
                motor_q  <= 1'b1;
              end
              CENTRIFUGAR: begin
                estado_q <= FRENADO;
                cuenta_q <= 9'(T_FRENADO);
                motor_q  <= 1'b0;
              end
              default: begin
                estado_q <= FIN;
                cuenta_q <= 9'd0;
                motor_q  <= 1'b0;
                vac_q    <= 1'b0;
                fin_q    <= 1'b1;
              end
            endcase
          else begin
            cuenta_q <= avanza ? cuenta_q - 9'd1 : cuenta_q;
            motor_q  <= estado_q == CENTRIFUGAR && !iPausa;
          end
        default: begin
          estado_q <= IDLE;
          cuenta_q <= 9'd0;
          motor_q  <= 1'b0;
          vac_q    <= 1'b0;
        end
      endcase
    end
  assign iLed_Motor    = motor_q;
  assign iLed_Vaceando = vac_q;
  assign iCuenta       = cuenta_q;
  assign iEstado       = estado_q;
  assign iFin          = fin_q;
  assign iError        = error_q;
endmodule

// File: tb/tb_centrifugado_temporizador.sv
// tb_centrifugado_temporizador: random-tick bench against an elapsed-tick reference model
module tb_centrifugado_temporizador;
  localparam int TF = 5;
  logic clk_in = 1'b0;
  logic iReset, iTick_1Hz, iCentrifugarL, iStart, iPausa;
  logic iCentri_1, iCentri_2, iCentri_3, iCentri_4;
  logic       motor_o [2];
  logic       vac_o   [2];
  logic [8:0] cuenta_o[2];
  logic [2:0] estado_o[2];
  logic       fin_o   [2];
  logic       err_o   [2];
  int total = 0, bad = 0;
  int  mode[2];
  int  t[2];
  int  spin[2];
  bit  err_m[2];
  bit  mot_m[2];
  int  tvk[2] = '{10, 1};
  always #5 clk_in = ~clk_in;
  centrifugado_temporizador dut_a (
    .clk_in(clk_in), .iReset(iReset), .iTick_1Hz(iTick_1Hz), .iCentrifugarL(iCentrifugarL),
    .iStart(iStart), .iPausa(iPausa), .iCentri_1(iCentri_1), .iCentri_2(iCentri_2),
    .iCentri_3(iCentri_3), .iCentri_4(iCentri_4), .iLed_Motor(motor_o[0]),
    .iLed_Vaceando(vac_o[0]), .iCuenta(cuenta_o[0]), .iEstado(estado_o[0]),
    .iFin(fin_o[0]), .iError(err_o[0])
  );
  centrifugado_temporizador #(.T_VACIAR(1)) dut_b (
    .clk_in(clk_in), .iReset(iReset), .iTick_1Hz(iTick_1Hz), .iCentrifugarL(iCentrifugarL),
    .iStart(iStart), .iPausa(iPausa), .iCentri_1(iCentri_1), .iCentri_2(iCentri_2),
    .iCentri_3(iCentri_3), .iCentri_4(iCentri_4), .iLed_Motor(motor_o[1]),
    .iLed_Vaceando(vac_o[1]), .iCuenta(cuenta_o[1]), .iEstado(estado_o[1]),
    .iFin(fin_o[1]), .iError(err_o[1])
  );
  // mode: 0 idle, 1 running (phase derived from elapsed ticks t), 2 done cycle
  function automatic int phase(int k);
    if (mode[k] == 0) return 0;
    if (mode[k] == 2) return 4;
    return t[k] < tvk[k] ? 1 : t[k] < tvk[k] + spin[k] ? 2 : 3;
  endfunction
  function automatic int cnt(int k);
    case (phase(k))
      1: return tvk[k] - t[k];
      2: return tvk[k] + spin[k] - t[k];
      3: return tvk[k] + spin[k] + TF - t[k];
      default: return 0;
    endcase
  endfunction
  function automatic int sel_time();
    return iCentri_1 ? 150 : iCentri_2 ? 200 : iCentri_3 ? 275 : 375;
  endfunction
  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mode[k] = 0; t[k] = 0; spin[k] = 0; err_m[k] = 0; mot_m[k] = 0;
    end
  endtask
  task automatic model_step();
    bit one;
    one = $countones({iCentri_4, iCentri_3, iCentri_2, iCentri_1}) == 1;
    for (int k = 0; k < 2; k++) begin
      if (mode[k] == 0) begin
        if (iStart && one && iCentrifugarL) begin
          mode[k] = 1; t[k] = 0; spin[k] = sel_time(); err_m[k] = 0;
        end else if (iStart && !one) err_m[k] = 1;
      end else if (mode[k] == 2) mode[k] = 0;
      else if (!iCentrifugarL) mode[k] = 0;
      else if (iTick_1Hz && !iPausa) begin
        t[k]++;
        if (t[k] == tvk[k] + spin[k] + TF) mode[k] = 2;
      end
      mot_m[k] = mode[k] == 1 && phase(k) == 2 && !iPausa;
    end
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask
  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("estado%0d", k), 32'(estado_o[k]), 32'(phase(k)));
      chk($sformatf("cuenta%0d", k), 32'(cuenta_o[k]), 32'(cnt(k)));
      chk($sformatf("motor%0d", k), 32'(motor_o[k]), 32'(mot_m[k]));
      chk($sformatf("vaceando%0d", k), 32'(vac_o[k]), 32'(mode[k] == 1));
      chk($sformatf("fin%0d", k), 32'(fin_o[k]), 32'(mode[k] == 2));
      chk($sformatf("error%0d", k), 32'(err_o[k]), 32'(err_m[k]));
    end
  endtask
  task automatic step(input bit tk, input bit pz);
    iTick_1Hz = tk;
    iPausa    = pz;
    @(posedge clk_in);
    model_step();
    #1;
    check_all();
  endtask
  task automatic bound(input string tag, input int n, input int budget);
    total++;
    assert (n < budget) else begin
      bad++;
      $error("FAIL %s timeout observed=%0d cycles expected<%0d", tag, n, budget);
    end
  endtask
  initial begin
    int n;
    iReset = 1'b1; iTick_1Hz = 0; iCentrifugarL = 1; iStart = 0; iPausa = 0;
    {iCentri_1, iCentri_2, iCentri_3, iCentri_4} = 4'b0000;
    model_reset();
    repeat (2) @(posedge clk_in);
    #1;
    check_all();
    iReset = 1'b0;
    // two selections high: stay idle, error raised
    iCentri_1 = 1; iCentri_3 = 1; iStart = 1;
    step(0, 0);
    chk("err_double_sel", 32'(err_o[0]), 32'd1);
    chk("idle_double_sel", 32'(estado_o[0]), 32'd0);
    iStart = 0;
    step(1, 0);
    // valid start with selection 4, then change the selection (must be ignored)
    iCentri_1 = 0; iCentri_3 = 0; iCentri_4 = 1; iStart = 1;
    step(0, 0);
    chk("err_cleared", 32'(err_o[0]), 32'd0);
    chk("b_vaciar_cnt1", 32'(cuenta_o[1]), 32'd1);
    iStart = 0; iCentri_4 = 0; iCentri_2 = 1;
    step(1, 1);
    chk("b_pause_at_one", 32'(estado_o[1]), 32'd1);
    step(1, 0);
    chk("b_spin_state", 32'(estado_o[1]), 32'd2);
    chk("b_spin375", 32'(cuenta_o[1]), 32'd375);
    n = 0;
    while ((mode[0] != 0 || mode[1] != 0) && n < 3000) begin
      step(1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0);
      n++;
    end
    bound("run375", n, 3000);
    // selection 2 with start held high; pause at count 120 for 30 ticks
    iStart = 1;
    step(0, 0);
    n = 0;
    while (!(phase(0) == 2 && cnt(0) == 120) && n < 2000) begin
      step(1'($urandom_range(0, 1)), 0);
      n++;
    end
    bound("reach120", n, 2000);
    repeat (30) step(1, 1);
    chk("pause_hold120", 32'(cuenta_o[0]), 32'd120);
    chk("pause_motor_off", 32'(motor_o[0]), 32'd0);
    step(1, 0);
    chk("resume119", 32'(cuenta_o[0]), 32'd119);
    chk("resume_motor_on", 32'(motor_o[0]), 32'd1);
    n = 0;
    while (mode[0] != 2 && n < 2000) begin
      step(1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0);
      n++;
    end
    bound("reach_fin", n, 2000);
    chk("fin_pulse", 32'(fin_o[0]), 32'd1);
    chk("fin_state", 32'(estado_o[0]), 32'd4);
    step(0, 0);
    chk("fin_to_idle", 32'(estado_o[0]), 32'd0);
    step(0, 0);
    chk("retrigger", 32'(estado_o[0]), 32'd1);
    iStart = 0;
    // abort in brake phase at count 3
    n = 0;
    while (!(phase(0) == 3 && cnt(0) == 3) && n < 1000) begin
      step(1, 0);
      n++;
    end
    bound("reach_brake3", n, 1000);
    iCentrifugarL = 0;
    step(1, 0);
    chk("abort_idle", 32'(estado_o[0]), 32'd0);
    chk("abort_leds", 32'({motor_o[0], vac_o[0]}), 32'd0);
    repeat (3) step(1, 0);
    chk("abort_no_fin", 32'(fin_o[0]), 32'd0);
    iCentrifugarL = 1;
    // asynchronous reset in the middle of spinning
    iCentri_2 = 0; iCentri_1 = 1; iStart = 1;
    step(0, 0);
    iStart = 0;
    n = 0;
    while (!(phase(0) == 2 && cnt(0) < 100) && n < 1000) begin
      step(1, 0);
      n++;
    end
    bound("reach_spin", n, 1000);
    #2 iReset = 1'b1;
    #1;
    chk("arst_estado", 32'(estado_o[0]), 32'd0);
    chk("arst_cuenta", 32'(cuenta_o[0]), 32'd0);
    chk("arst_leds", 32'({motor_o[0], vac_o[0], fin_o[0], err_o[0]}), 32'd0);
    model_reset();
    @(posedge clk_in);
    #1 iReset = 1'b0;
    step(1, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/centrifugado_temporizador.md
Name: centrifugado_temporizador

Overview:
- Spin-cycle sequencer placed directly downstream of the spin-time selector.
- Consumes the one-hot spin-time selection (iCentri_1..4).
- On a start request, latches the selection and runs three timed phases from a 1 Hz tick enable: drain, spin, brake.
- Drives the motor and drain-pump LEDs, exposes the phase countdown for the display path, and pulses a done flag back to the master washer FSM.

Parameters:
- T_CENTRI_1, 150, spin seconds when iCentri_1 is selected.
- T_CENTRI_2, 200, spin seconds when iCentri_2 is selected.
- T_CENTRI_3, 275, spin seconds when iCentri_3 is selected.
- T_CENTRI_4, 375, spin seconds when iCentri_4 is selected.
- T_VACIAR, 10, drain seconds before spin.
- T_FRENADO, 5, brake seconds after spin.
- All parameters must be in the range 1..511; 0 is illegal.

Ports:
- clk_in  input  1  system clock
- iReset  input  1  asynchronous active-high reset
- iTick_1Hz  input  1  one-clk_in-cycle pulse, once per second, synchronous to clk_in
- iCentrifugarL  input  1  level; spin program enabled
- iStart  input  1  level/pulse; start request, sampled only in IDLE
- iPausa  input  1  level; freeze countdown, motor off
- iCentri_1, iCentri_2, iCentri_3, iCentri_4  input  1 each  one-hot spin-time selection
- iLed_Motor  output  1  drum motor on
- iLed_Vaceando  output  1  drain pump on
- iCuenta  output  9  seconds remaining in current phase
- iEstado  output  3  state code: 0 IDLE, 1 VACIAR, 2 CENTRIFUGAR, 3 FRENADO, 4 FIN
- iFin  output  1  one-cycle done pulse
- iError  output  1  sticky invalid-selection flag

Behaviour:
- Reset (async, iReset=1): state IDLE, iCuenta=0, iLed_Motor=0, iLed_Vaceando=0, iFin=0, iError=0, latched time=0. All registers are clocked on posedge clk_in.
- IDLE:
  - iStart=1, iCentrifugarL=1 and exactly one iCentri_x high: latch T_CENTRI_x; next edge goes to VACIAR, iCuenta=T_VACIAR, iError cleared.
  - iStart=1 with zero or more than one selection high: stay IDLE, iError<=1 (held until the next valid start or reset).
- Countdown rule, all timed states:
  - On a clock where iTick_1Hz=1 and iPausa=0: if iCuenta>1, decrement by 1; if iCuenta==1, move to the next phase and load its duration.
  - Each phase therefore lasts exactly N ticks. No wrap-around; iCuenta never reaches 0 inside a timed state.
- VACIAR: iLed_Vaceando=1, iLed_Motor=0. On expiry goes to CENTRIFUGAR with the latched time.
- CENTRIFUGAR: iLed_Vaceando=1; iLed_Motor=1 unless iPausa=1. On expiry goes to FRENADO with T_FRENADO.
- FRENADO: iLed_Motor=0, iLed_Vaceando=1. On expiry goes to FIN.
- FIN: one cycle long. iFin=1, iCuenta=0, both LEDs 0. Next edge goes to IDLE.
- LED outputs are registered and update on the same edge as the state change.
- Pause: iPausa=1 freezes iCuenta and the state and forces iLed_Motor=0. A tick coincident with pause is ignored (pause wins). Release resumes from the held count.
- iCentrifugarL=0 in any non-IDLE state: abort to IDLE on the next edge, iCuenta=0, LEDs 0, no iFin pulse.
- iStart outside IDLE is ignored. Selection changes after start are ignored (value is latched).
- iStart held high through FIN→IDLE re-triggers a new run on the edge after IDLE is entered.

Test Plan:
- Reset: assert iReset mid-CENTRIFUGAR asynchronously → all outputs 0 and iEstado=0 immediately, before the next edge.
- Normal run: iCentri_2=1, iStart pulse, 215 ticks → VACIAR for 10 ticks, CENTRIFUGAR for 200 (iCuenta 200→1), FRENADO for 5, then one iFin pulse and iEstado 4→0. iLed_Motor is high only during the 200 spin ticks.
- Pause: in CENTRIFUGAR at iCuenta=120, hold iPausa for 30 ticks → iCuenta stays 120 and iLed_Motor=0. On release the count resumes at 119 after the next tick; total spin ticks counted = 200.
- Invalid selection: iCentri_1=iCentri_3=1 with iStart → stays IDLE, iError=1. Then iCentri_4 alone with iStart → iError=0, spin phase loads 375.
- Abort: drop iCentrifugarL in FRENADO at iCuenta=3 → IDLE next edge, iFin never pulses, LEDs 0.
- Tick/pause coincidence and boundary: T_VACIAR=1 override → VACIAR exits on the first tick. A tick with iPausa=1 at iCuenta=1 → no transition.
